// File: rtl/loadreg_bank_pkg.sv
// Shared game package: press-tracking state encoding and bank mode selectors.
package loadreg_bank_pkg;

    // Button tracking states: Store waits for a press, Load waits for release.
    typedef enum logic {
        ST_STORE = 1'b0,
        ST_LOAD  = 1'b1
    } press_state_e;

    // Bank behaviour once every entry is occupied.
    localparam int MODE_SHIFT = 0;  // oldest entry dropped on a new capture
    localparam int MODE_STOP  = 1;  // new captures ignored, overflow flagged

endpackage

// File: rtl/loadreg_bank_press_detect.sv
// Two-state button tracker. Emits a one-cycle capture strobe on the first
// sampled high level of sig_load after a low level. Reset lands in Load so a
// button held through reset must be released before it can capture.
module press_detect
    import loadreg_bank_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    output logic         capture_o,
    output press_state_e state_o
);

    press_state_e state_q;
    press_state_e state_d;

    // Next state: a clear re-synchronises to the current button level.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = load_i ? ST_LOAD : ST_STORE;
        end else begin
            case (state_q)
                ST_STORE: if (load_i)  state_d = ST_LOAD;
                ST_LOAD:  if (!load_i) state_d = ST_STORE;
                default:               state_d = ST_LOAD;
            endcase
        end
    end

    // State register with synchronous reset into Load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe must act on the same edge that sees the press, so it is decoded
    // from the registered state and the live button level; a clear masks it.
    assign capture_o = (state_q == ST_STORE) && load_i && !clear_i;
    assign state_o   = state_q;

endmodule

// File: rtl/loadreg_bank.sv
// History bank of player values. Each button press captures data_in into
// entry 0, pushing older entries up. Entry 0 is always the newest value.
// rd_data gives a zero-latency indexed view; unused entries read as zero.
// dbg_state exposes the press tracker state (1 = waiting for release).
module loadreg_bank
    import loadreg_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int MODE  = MODE_SHIFT
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       sig_load,
    input  logic                       sig_clear,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           data_out,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic                       load_pulse,
    output logic                       dbg_state
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             load_pulse_q, load_pulse_d;

    logic             capture;
    logic             accept;
    press_state_e     press_state;

    press_detect u_press_detect (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (sig_clear),
        .load_i    (sig_load),
        .capture_o (capture),
        .state_o   (press_state)
    );

    // A capture commits unless stop mode has no free entry left.
    assign accept = capture && ((MODE == MODE_SHIFT) || (count_q != CNT_MAX));

    // Next bank contents, occupancy and flags; clear wins over any capture.
    always_comb begin
        bank_d       = bank_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        load_pulse_d = 1'b0;
        if (sig_clear) begin
            for (int i = 0; i < DEPTH; i++) bank_d[i] = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            for (int i = DEPTH - 1; i > 0; i--) bank_d[i] = bank_q[i-1];
            bank_d[0]    = data_in;
            count_d      = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;
            load_pulse_d = 1'b1;
        end else if (capture) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset overriding clear and load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            load_pulse_q <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            load_pulse_q <= load_pulse_d;
        end
    end

    // Indexed read: only occupied entries are visible, others (and any index
    // past DEPTH) read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((int'(rd_idx) == i) && (i < int'(count_q))) rd_data = bank_q[i];
        end
    end

    assign data_out   = bank_q[0];
    assign count      = count_q;
    assign full       = (count_q == CNT_MAX);
    assign overflow   = overflow_q;
    assign load_pulse = load_pulse_q;
    assign dbg_state  = press_state;

endmodule

// File: tb/tb_loadreg_bank.sv
// Directed bench for loadreg_bank. Two instances (shift and stop mode) share
// all stimulus; each scenario task checks whichever instance it targets.
module tb_loadreg_bank;
  import loadreg_bank_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  logic         CLK;
  logic         RST;
  logic [W-1:0] data_in;
  logic         sig_load;
  logic         sig_clear;
  logic [1:0]   rd_idx;

  logic [W-1:0] sh_data_out, sh_rd_data, st_data_out, st_rd_data;
  logic [2:0]   sh_count, st_count;
  logic         sh_full, sh_overflow, sh_load_pulse, sh_dbg_state;
  logic         st_full, st_overflow, st_load_pulse, st_dbg_state;

  int checks = 0;
  int errors = 0;

  loadreg_bank #(.WIDTH(W), .DEPTH(D), .MODE(MODE_SHIFT)) u_shift (
    .CLK(CLK), .RST(RST), .data_in(data_in), .sig_load(sig_load),
    .sig_clear(sig_clear), .rd_idx(rd_idx), .data_out(sh_data_out),
    .rd_data(sh_rd_data), .count(sh_count), .full(sh_full),
    .overflow(sh_overflow), .load_pulse(sh_load_pulse), .dbg_state(sh_dbg_state)
  );

  loadreg_bank #(.WIDTH(W), .DEPTH(D), .MODE(MODE_STOP)) u_stop (
    .CLK(CLK), .RST(RST), .data_in(data_in), .sig_load(sig_load),
    .sig_clear(sig_clear), .rd_idx(rd_idx), .data_out(st_data_out),
    .rd_data(st_rd_data), .count(st_count), .full(st_full),
    .overflow(st_overflow), .load_pulse(st_load_pulse), .dbg_state(st_dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge; outputs are sampled 1ns after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Driver: one full press/release with a given value.
  task automatic press(input logic [W-1:0] v);
    sig_load = 1'b1;
    data_in  = v;
    tick();
    sig_load = 1'b0;
    tick();
  endtask

  // Driver: one-cycle clear with the button released.
  task automatic do_clear();
    sig_clear = 1'b1;
    sig_load  = 1'b0;
    tick();
    sig_clear = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    sig_load = 1'b1;
    sig_clear = 1'b0;
    data_in = 4'h0;
    rd_idx = 2'd0;
    tick();
    tick();
    checks++;
    if (sh_data_out !== 4'h0 || sh_rd_data !== 4'h0 || sh_count !== 3'd0 ||
        sh_full !== 1'b0 || sh_overflow !== 1'b0 || sh_load_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%0h rd=%0h cnt=%0d full=%b ovf=%b pulse=%b, expected all 0",
               sh_data_out, sh_rd_data, sh_count, sh_full, sh_overflow, sh_load_pulse);
    end
    checks++;
    if (sh_dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got %b expected 1 (Load)", sh_dbg_state);
    end
    // Release reset with the button still held: no capture allowed.
    RST = 1'b0;
    tick();
    checks++;
    if (sh_count !== 3'd0 || sh_load_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_button: got cnt=%0d pulse=%b expected cnt=0 pulse=0", sh_count, sh_load_pulse);
    end
    sig_load = 1'b0;
    tick();
    sig_load = 1'b1;
    data_in = 4'h5;
    tick();
    checks++;
    if (sh_data_out !== 4'h5 || sh_count !== 3'd1 || sh_load_pulse !== 1'b1) begin
      errors++;
      $display("FAIL first_capture: got out=%0h cnt=%0d pulse=%b expected out=5 cnt=1 pulse=1",
               sh_data_out, sh_count, sh_load_pulse);
    end
    sig_load = 1'b0;
    tick();
    checks++;
    if (sh_load_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: got %b expected 0", sh_load_pulse);
    end
  endtask

  task automatic test_held_button();
    int pulses;
    do_clear();
    pulses = 0;
    sig_load = 1'b1;
    data_in = 4'h3;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sh_load_pulse === 1'b1) pulses++;
      data_in = 4'(4 + (i * 5) / 9);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL held_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (sh_data_out !== 4'h3 || sh_count !== 3'd1) begin
      errors++;
      $display("FAIL held_capture: got out=%0h cnt=%0d expected out=3 cnt=1", sh_data_out, sh_count);
    end
    sig_load = 1'b0;
    tick();
  endtask

  task automatic test_shift_mode();
    logic [W-1:0] exp_rd [4];
    exp_rd[0] = 4'h5; exp_rd[1] = 4'h4; exp_rd[2] = 4'h3; exp_rd[3] = 4'h2;
    do_clear();
    for (int v = 1; v <= 5; v++) press(4'(v));
    checks++;
    if (sh_full !== 1'b1 || sh_count !== 3'd4 || sh_overflow !== 1'b0) begin
      errors++;
      $display("FAIL shift_full: got full=%b cnt=%0d ovf=%b expected full=1 cnt=4 ovf=0",
               sh_full, sh_count, sh_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (sh_rd_data !== exp_rd[i]) begin
        errors++;
        $display("FAIL shift_rd[%0d]: got %0h expected %0h", i, sh_rd_data, exp_rd[i]);
      end
    end
    // After a clear and one capture, entries past count read zero.
    do_clear();
    rd_idx = 2'd0;
    #1;
    checks++;
    if (sh_rd_data !== 4'h0 || sh_full !== 1'b0) begin
      errors++;
      $display("FAIL cleared_rd0: got rd=%0h full=%b expected rd=0 full=0", sh_rd_data, sh_full);
    end
    press(4'h9);
    rd_idx = 2'd1;
    #1;
    checks++;
    if (sh_rd_data !== 4'h0) begin
      errors++;
      $display("FAIL beyond_count_rd1: got %0h expected 0", sh_rd_data);
    end
    rd_idx = 2'd0;
    #1;
    checks++;
    if (sh_rd_data !== 4'h9) begin
      errors++;
      $display("FAIL newest_rd0: got %0h expected 9", sh_rd_data);
    end
  endtask

  task automatic test_stop_mode();
    logic [W-1:0] exp_rd [4];
    exp_rd[0] = 4'h4; exp_rd[1] = 4'h3; exp_rd[2] = 4'h2; exp_rd[3] = 4'h1;
    do_clear();
    for (int v = 1; v <= 4; v++) press(4'(v));
    checks++;
    if (st_overflow !== 1'b0 || st_full !== 1'b1) begin
      errors++;
      $display("FAIL stop_before_over: got ovf=%b full=%b expected ovf=0 full=1", st_overflow, st_full);
    end
    sig_load = 1'b1;
    data_in = 4'h5;
    tick();
    checks++;
    if (st_load_pulse !== 1'b0 || st_overflow !== 1'b1 || st_dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL stop_fifth_press: got pulse=%b ovf=%b st=%b expected pulse=0 ovf=1 st=1",
               st_load_pulse, st_overflow, st_dbg_state);
    end
    sig_load = 1'b0;
    tick();
    checks++;
    if (st_count !== 3'd4 || st_data_out !== 4'h4 || st_overflow !== 1'b1) begin
      errors++;
      $display("FAIL stop_hold: got cnt=%0d out=%0h ovf=%b expected cnt=4 out=4 ovf=1",
               st_count, st_data_out, st_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (st_rd_data !== exp_rd[i]) begin
        errors++;
        $display("FAIL stop_rd[%0d]: got %0h expected %0h", i, st_rd_data, exp_rd[i]);
      end
    end
    checks++;
    if (sh_overflow !== 1'b0 || sh_data_out !== 4'h5) begin
      errors++;
      $display("FAIL shift_no_overflow: got ovf=%b out=%0h expected ovf=0 out=5", sh_overflow, sh_data_out);
    end
  endtask

  task automatic test_clear_vs_load();
    // Stop instance still carries overflow and a full bank from the last test.
    sig_clear = 1'b1;
    sig_load = 1'b1;
    data_in = 4'h7;
    rd_idx = 2'd0;
    tick();
    checks++;
    if (st_count !== 3'd0 || st_data_out !== 4'h0 || st_overflow !== 1'b0 || st_load_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins_stop: got cnt=%0d out=%0h ovf=%b pulse=%b expected all 0",
               st_count, st_data_out, st_overflow, st_load_pulse);
    end
    checks++;
    if (sh_count !== 3'd0 || sh_data_out !== 4'h0 || sh_load_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins_shift: got cnt=%0d out=%0h pulse=%b expected all 0",
               sh_count, sh_data_out, sh_load_pulse);
    end
    // Button held through the clear must not capture.
    sig_clear = 1'b0;
    tick();
    checks++;
    if (sh_count !== 3'd0 || sh_load_pulse !== 1'b0) begin
      errors++;
      $display("FAIL held_through_clear: got cnt=%0d pulse=%b expected cnt=0 pulse=0", sh_count, sh_load_pulse);
    end
    sig_load = 1'b0;
    tick();
    press(4'h6);
    checks++;
    if (sh_count !== 3'd1 || sh_data_out !== 4'h6 || st_count !== 3'd1 || st_data_out !== 4'h6) begin
      errors++;
      $display("FAIL after_clear_capture: got sh=%0d/%0h st=%0d/%0h expected 1/6 for both",
               sh_count, sh_data_out, st_count, st_data_out);
    end
  endtask

  task automatic test_back_to_back();
    // Minimum spacing: high, low, high captures twice.
    do_clear();
    sig_load = 1'b1; data_in = 4'hA; tick();
    sig_load = 1'b0; tick();
    sig_load = 1'b1; data_in = 4'hB; tick();
    checks++;
    if (sh_count !== 3'd2 || sh_data_out !== 4'hB || sh_load_pulse !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: got cnt=%0d out=%0h pulse=%b expected cnt=2 out=b pulse=1",
               sh_count, sh_data_out, sh_load_pulse);
    end
    sig_load = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    do_clear();
    press(4'h1);
    press(4'h2);
    sig_load = 1'b1;
    data_in = 4'h3;
    tick();
    checks++;
    if (sh_count !== 3'd3 || sh_dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hold: got cnt=%0d st=%b expected cnt=3 st=1", sh_count, sh_dbg_state);
    end
    RST = 1'b1;
    tick();
    rd_idx = 2'd0;
    #1;
    checks++;
    if (sh_data_out !== 4'h0 || sh_rd_data !== 4'h0 || sh_count !== 3'd0 ||
        sh_full !== 1'b0 || sh_load_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: got out=%0h rd=%0h cnt=%0d full=%b pulse=%b expected all 0",
               sh_data_out, sh_rd_data, sh_count, sh_full, sh_load_pulse);
    end
    RST = 1'b0;
    sig_load = 1'b0;
    tick();
    press(4'h8);
    checks++;
    if (sh_count !== 3'd1 || sh_data_out !== 4'h8) begin
      errors++;
      $display("FAIL repress_after_reset: got cnt=%0d out=%0h expected cnt=1 out=8", sh_count, sh_data_out);
    end
  endtask

  initial begin
    test_reset();
    test_held_button();
    test_shift_mode();
    test_stop_mode();
    test_clear_vs_load();
    test_back_to_back();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
